// File: rtl/pc_sequencer.sv
// Program-counter owner and fetch/execute sequencer for the CPU core.
// Fetches over a req/ack handshake, latches the instruction, and selects the next PC on exec_done.
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic             inst_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_4,
    input  logic             exec_done,
    input  logic             is_jump,
    input  logic             is_jr,
    input  logic [31:0]      jr_addr,
    input  logic             is_branch,
    input  logic             branch_taken,
    input  logic             halt_req,
    output logic             halted,
    output logic             align_err,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      inst_reg, inst_next;
    logic             align_err_reg, align_err_next;
    logic [CNT_W-1:0] retired_cnt_reg, retired_cnt_next;

    logic [31:0]      pc_plus4;
    logic [31:0]      jump_target;
    logic [31:0]      branch_off;
    logic [31:0]      next_pc;

    assign pc_plus4    = pc_reg + 32'd4;
    assign jump_target = {pc_plus4[31:28], inst_reg[25:0], 2'b00};
    assign branch_off  = {{14{inst_reg[15]}}, inst_reg[15:0], 2'b00};

    // Redirect priority: register jump, then region jump, then taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (is_jr)
            next_pc = jr_addr;
        else if (is_jump)
            next_pc = jump_target;
        else if (is_branch && branch_taken)
            next_pc = pc_plus4 + branch_off;
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        inst_next        = inst_reg;
        align_err_next   = align_err_reg;
        retired_cnt_next = retired_cnt_reg;
        case (state_reg)
            BOOT: state_next = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    inst_next  = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    pc_next          = next_pc;
                    retired_cnt_next = retired_cnt_reg + CNT_W'(1);
                    // A misaligned target still retires the instruction but stops the core.
                    if (next_pc[1:0] != 2'b00) begin
                        align_err_next = 1'b1;
                        state_next     = HALT;
                    end else if (halt_req) begin
                        state_next = HALT;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            HALT: state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_ADDR;
            inst_reg        <= 32'h0;
            align_err_reg   <= 1'b0;
            retired_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            inst_reg        <= inst_next;
            align_err_reg   <= align_err_next;
            retired_cnt_reg <= retired_cnt_next;
        end
    end

    assign imem_req    = (state_reg == FETCH);
    assign imem_addr   = pc_reg;
    assign inst        = inst_reg;
    assign inst_valid  = (state_reg == EXEC);
    assign pc          = pc_reg;
    assign pc_4        = pc_plus4;
    assign halted      = (state_reg == HALT);
    assign align_err   = align_err_reg;
    assign retired_cnt = retired_cnt_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: fetch handshake, next-PC selection, halts and reset.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_4;
    logic        exec_done;
    logic        is_jump;
    logic        is_jr;
    logic [31:0] jr_addr;
    logic        is_branch;
    logic        branch_taken;
    logic        halt_req;
    logic        halted;
    logic        align_err;
    logic [31:0] retired_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_ret = 32'd0;

    pc_sequencer #(.RESET_ADDR(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_4(pc_4),
        .exec_done(exec_done), .is_jump(is_jump), .is_jr(is_jr), .jr_addr(jr_addr),
        .is_branch(is_branch), .branch_taken(branch_taken), .halt_req(halt_req),
        .halted(halted), .align_err(align_err), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a negedge while in FETCH; acks after 'waits' idle cycles.
    task automatic fetch(input logic [31:0] addr, input int waits, input logic [31:0] data);
        for (int i = 0; i <= waits; i++) begin
            check("fetch_req", {31'd0, imem_req}, 32'd1);
            check("fetch_addr", imem_addr, addr);
            if (i == waits) begin
                imem_ack   = 1'b1;
                imem_rdata = data;
            end
            @(negedge clk);
        end
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("inst_valid", {31'd0, inst_valid}, 32'd1);
        check("inst", inst, data);
        $display("fetch addr=%h waits=%0d inst=%h", addr, waits, inst);
    endtask

    // Called at a negedge while in EXEC; pulses exec_done with the given redirect flags.
    task automatic exec(input logic jmp, input logic jr, input logic [31:0] jra,
                        input logic br, input logic tkn, input logic hlt,
                        input logic [31:0] exp_pc, input logic exp_halt, input logic exp_align);
        exec_done    = 1'b1;
        is_jump      = jmp;
        is_jr        = jr;
        jr_addr      = jra;
        is_branch    = br;
        branch_taken = tkn;
        halt_req     = hlt;
        @(negedge clk);
        exec_done = 1'b0; is_jump = 1'b0; is_jr = 1'b0; jr_addr = 32'h0;
        is_branch = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;
        exp_ret = exp_ret + 32'd1;
        check("next_pc", pc, exp_pc);
        check("retired_cnt", retired_cnt, exp_ret);
        check("halted", {31'd0, halted}, {31'd0, exp_halt});
        check("align_err", {31'd0, align_err}, {31'd0, exp_align});
        check("req_after_exec", {31'd0, imem_req}, {31'd0, ~exp_halt});
        $display("exec pc=%h retired=%0d halted=%b align_err=%b", pc, retired_cnt, halted, align_err);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        exec_done = 1'b0; is_jump = 1'b0; is_jr = 1'b0; jr_addr = 32'h0;
        is_branch = 1'b0; branch_taken = 1'b0; halt_req = 1'b0;

        // Reset state, then BOOT for one cycle before FETCH.
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_align", {31'd0, align_err}, 32'd0);
        check("rst_retired", retired_cnt, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Instruction held stable while exec_done is low; a stray ack in EXEC is ignored.
        fetch(32'h0, 0, 32'h2008_0005);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        check("exec_hold_inst", inst, 32'h2008_0005);
        check("exec_hold_valid", {31'd0, inst_valid}, 32'd1);
        check("exec_hold_pc", pc, 32'h0);
        check("exec_no_req", {31'd0, imem_req}, 32'd0);
        exec(0, 0, 32'h0, 0, 0, 0, 32'h4, 0, 0);

        // Sequential flow with three wait cycles per fetch.
        fetch(32'h4, 3, 32'h0000_0000);
        exec(0, 0, 32'h0, 0, 0, 0, 32'h8, 0, 0);
        fetch(32'h8, 3, 32'h0000_0000);
        exec(0, 0, 32'h0, 0, 0, 0, 32'hC, 0, 0);

        // Register jump, region jump, and jr beating jump.
        fetch(32'hC, 0, 32'h0000_0000);
        exec(0, 1, 32'h1000_0040, 0, 0, 0, 32'h1000_0040, 0, 0);
        fetch(32'h1000_0040, 1, 32'h0800_0010);
        exec(1, 0, 32'h0, 0, 0, 0, 32'h1000_0040, 0, 0);
        fetch(32'h1000_0040, 0, 32'h0800_0010);
        exec(1, 1, 32'h0000_0200, 0, 0, 0, 32'h0000_0200, 0, 0);

        // Backward branch taken / not taken, branch_taken without is_branch, jump beats branch.
        fetch(32'h200, 0, 32'h0);
        exec(0, 1, 32'h0000_0100, 0, 0, 0, 32'h0000_0100, 0, 0);
        fetch(32'h100, 0, 32'h1000_FFFE);
        exec(0, 0, 32'h0, 1, 1, 0, 32'h0000_00FC, 0, 0);
        fetch(32'hFC, 0, 32'h0);
        exec(0, 1, 32'h0000_0100, 0, 0, 0, 32'h0000_0100, 0, 0);
        fetch(32'h100, 0, 32'h1000_FFFE);
        exec(0, 0, 32'h0, 1, 0, 0, 32'h0000_0104, 0, 0);
        fetch(32'h104, 0, 32'h1000_FFFE);
        exec(0, 0, 32'h0, 0, 1, 0, 32'h0000_0108, 0, 0);
        fetch(32'h108, 0, 32'h0800_0010);
        exec(1, 0, 32'h0, 1, 1, 0, 32'h0000_0040, 0, 0);

        // PC wrap at the top of the address space.
        fetch(32'h40, 0, 32'h0);
        exec(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        check("pc_4_wrap", pc_4, 32'h0);
        fetch(32'hFFFF_FFFC, 0, 32'h0);
        exec(0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0);

        // exec_done and halt_req during a fetch wait are ignored.
        exec_done = 1'b1; halt_req = 1'b1;
        @(negedge clk);
        exec_done = 1'b0; halt_req = 1'b0;
        check("fetch_ignore_done_ret", retired_cnt, exp_ret);
        check("fetch_ignore_done_pc", pc, 32'h0);
        check("fetch_ignore_halt", {31'd0, halted}, 32'd0);
        fetch(32'h0, 0, 32'h0);

        // Misaligned register target halts with align_err.
        exec(0, 1, 32'h0000_0102, 0, 0, 0, 32'h0000_0102, 1, 1);
        repeat (3) @(negedge clk);
        check("halt_no_req", {31'd0, imem_req}, 32'd0);
        check("halt_stays", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, inst_valid}, 32'd0);

        // halt_req with exec_done after a fresh reset.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 32'd0;
        check("rst2_align", {31'd0, align_err}, 32'd0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        fetch(32'h0, 0, 32'h0);
        exec(0, 0, 32'h0, 0, 0, 1, 32'h4, 1, 0);

        // Reset during a fetch wait with the ack landing in the reset cycle.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ret = 32'd0;
        @(negedge clk);
        check("refetch_req", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = 32'h0;
        check("late_ack_valid", {31'd0, inst_valid}, 32'd0);
        check("late_ack_inst", inst, 32'h0);
        check("late_ack_req", {31'd0, imem_req}, 32'd0);
        check("late_ack_pc", pc, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(32'h0, 1, 32'h2008_0005);
        exec(0, 0, 32'h0, 0, 0, 0, 32'h4, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
